// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StRd0,
    StWr1,
    StRd1,
    StCheck,
    StDone
  } bist_state_e;

  localparam int unsigned MaxWidth = 64;

  // Swap the upper and lower halves of the low `width` bits of d.
  function automatic logic [MaxWidth-1:0] half_swap(input logic [MaxWidth-1:0] d,
                                                     input int unsigned width);
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] dm;
    mask = (width >= MaxWidth) ? '1 : ((MaxWidth'(1) << width) - MaxWidth'(1));
    dm   = d & mask;
    return ((dm >> (width / 2)) | (dm << (width / 2))) & mask;
  endfunction

endpackage

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write P, read up, write ~P, read down, with a one-cycle
// registered compare stage that checks mem_rdata the cycle after each read.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned PSIZE = 2,
  parameter int unsigned DEPTH = 2 ** PSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [PSIZE-1:0] fail_addr,
  output logic [PSIZE+1:0] err_count
);

  localparam logic [PSIZE-1:0] LastAddr = PSIZE'(DEPTH - 1);
  localparam logic [PSIZE-1:0] HalfAddr = PSIZE'(DEPTH / 2);

  bist_state_e      state_q, state_d;
  logic [PSIZE-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q;
  logic             accept;
  logic             last;

  logic             cmp_valid_q;
  logic [PSIZE-1:0] cmp_addr_q;
  logic [WIDTH-1:0] cmp_exp_q;
  logic [WIDTH-1:0] rd_base;
  logic [WIDTH-1:0] rd_swap;
  logic [WIDTH-1:0] rd_exp;
  logic             mismatch;

  logic [PSIZE+1:0] err_count_q;
  logic [PSIZE-1:0] fail_addr_q;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign last   = (cnt_q == LastAddr);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wdata   = '0;
    mem_wr_addr = '0;
    mem_rd_addr = '0;
    busy        = 1'b0;
    rd_base     = pat_q;
    unique case (state_q)
      StIdle, StDone: begin
        cnt_d = '0;
        if (accept) state_d = StWr0;
      end
      StWr0: begin
        mem_wr      = 1'b1;
        mem_wr_addr = cnt_q;
        mem_wdata   = pat_q;
        busy        = 1'b1;
        if (last) state_d = StRd0;
      end
      StRd0: begin
        mem_rd      = 1'b1;
        mem_rd_addr = cnt_q;
        busy        = 1'b1;
        if (last) state_d = StWr1;
      end
      StWr1: begin
        mem_wr      = 1'b1;
        mem_wr_addr = cnt_q;
        mem_wdata   = ~pat_q;
        busy        = 1'b1;
        if (last) state_d = StRd1;
      end
      StRd1: begin
        mem_rd      = 1'b1;
        mem_rd_addr = LastAddr - cnt_q;
        rd_base     = ~pat_q;
        busy        = 1'b1;
        if (last) state_d = StCheck;
      end
      StCheck: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    // One shared counter walks every march phase and wraps at the phase boundary.
    if (mem_wr || mem_rd) cnt_d = last ? '0 : cnt_q + PSIZE'(1);
  end

  // Upper half of the array stores words half-swapped.
  assign rd_swap  = WIDTH'(half_swap(MaxWidth'(rd_base), WIDTH));
  assign rd_exp   = (mem_rd_addr < HalfAddr) ? rd_base : rd_swap;
  assign mismatch = cmp_valid_q && (mem_rdata != cmp_exp_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pat_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      err_count_q <= '0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmp_valid_q <= mem_rd;
      cmp_addr_q  <= mem_rd_addr;
      cmp_exp_q   <= mem_rd ? rd_exp : '0;
      if (accept) begin
        pat_q       <= pattern;
        err_count_q <= '0;
        fail_addr_q <= '0;
      end else if (mismatch) begin
        if (err_count_q == '0) fail_addr_q <= cmp_addr_q;
        if (err_count_q != '1) err_count_q <= err_count_q + (PSIZE + 2)'(1);
      end
    end
  end

  assign done      = (state_q == StDone);
  assign pass      = done && (err_count_q == '0);
  assign fail_addr = fail_addr_q;
  assign err_count = err_count_q;

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 2, data width; WIDTH SHALL be even.
REQ-002 SHALL provide parameter PSIZE, default 2, address width.
REQ-003 SHALL provide parameter DEPTH, default 2**PSIZE, number of words tested.
REQ-004 SHALL provide clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide start  input  1  single-cycle request to run the test.
REQ-007 SHALL provide pattern  input  WIDTH  base test word, sampled when start is accepted.
REQ-008 SHALL provide mem_wr  output  1  write strobe to the memory.
REQ-009 SHALL provide mem_rd  output  1  read strobe to the memory.
REQ-010 SHALL provide mem_wdata  output  WIDTH  write data.
REQ-011 SHALL provide mem_wr_addr  output  PSIZE  write address.
REQ-012 SHALL provide mem_rd_addr  output  PSIZE  read address.
REQ-013 SHALL provide mem_rdata  input  WIDTH  memory read data, valid one cycle after mem_rd.
REQ-014 SHALL provide busy  output  1  test in progress.
REQ-015 SHALL provide done  output  1  test finished; held until next accepted start or reset.
REQ-016 SHALL provide pass  output  1  valid while done: 1 = no mismatch.
REQ-017 SHALL provide fail_addr  output  PSIZE  address of first mismatch.
REQ-018 SHALL provide err_count  output  PSIZE+2  mismatch count, saturating at all-ones.

Function
REQ-019 FSM states SHALL be IDLE, WR0, RD0, WR1, RD1, CHECK, DONE.
REQ-020 start in IDLE or DONE SHALL be accepted: latch P = pattern, clear done/pass/fail_addr/err_count, enter WR0 next cycle; start in any other state SHALL be ignored.
REQ-021 WR0: one write per cycle, addresses 0..DEPTH-1 ascending, mem_wdata = P; exactly DEPTH cycles.
REQ-022 RD0: one read per cycle, addresses 0..DEPTH-1 ascending; DEPTH cycles.
REQ-023 WR1: as WR0 with mem_wdata = ~P.
REQ-024 RD1: reads addresses DEPTH-1..0 descending; DEPTH cycles.
REQ-025 CHECK: one cycle, no strobes, completes the final compare; then DONE.
REQ-026 mem_wr and mem_rd SHALL never be high in the same cycle; both SHALL be low in IDLE, CHECK, DONE.
REQ-027 Each read SHALL register (cmp_valid, cmp_addr, cmp_exp); compare against mem_rdata in the following cycle, independent of FSM state.
REQ-028 Expected word for data D at address A: D if A < DEPTH/2, else swap(D) = {D[WIDTH/2-1:0], D[WIDTH-1:WIDTH/2]}.
REQ-029 On mismatch: increment err_count (saturating); if first mismatch of the run, capture fail_addr = cmp_addr.
REQ-030 busy SHALL be high in WR0..CHECK; done SHALL be high only in DONE; pass = done && err_count == 0.
REQ-031 Timing: start accepted at edge 0 -> busy from cycle 1, done from cycle 4*DEPTH+2 (18 for DEPTH=4).
REQ-032 Unused output data/address fields SHALL be driven to 0 when their strobe is low.

Reset
REQ-033 rst_n low SHALL, at the next clk edge, force IDLE and zero every output, P, and the compare pipeline.
REQ-034 Reset mid-run SHALL abort without further strobes; a pending compare SHALL be discarded.
REQ-035 start coincident with rst_n low SHALL be ignored.

Structure
REQ-036 Package mem_bist_pkg SHALL hold the state enum and the half-swap function.
REQ-037 Address counter, FSM and compare stage SHALL be in mem_bist_ctrl; no sub-module.

Verification
REQ-038 WIDTH=2, DEPTH=4, paired with the team memory, pattern=2'b01 -> reads return 01,01,10,10 (RD0); done at cycle 18, pass=1, err_count=0.
REQ-039 Force mem_rdata to 2'b00 only on the RD0 return for address 2 -> pass=0, fail_addr=2, err_count=1.
REQ-040 Force mem_rdata stuck at 2'b11 throughout, pattern=2'b00 -> RD0 all 4 mismatches and RD1 none; err_count=4, fail_addr=0.
REQ-041 Pulse start again at cycle 5 of a run -> ignored; done still at cycle 18, strobe sequence unchanged.
REQ-042 Drop rst_n during RD0 -> next cycle IDLE, all outputs 0, no strobes; new start runs a clean full test with pass=1.
REQ-043 Every cycle: assert !(mem_wr && mem_rd), and that mem_rd is followed by exactly one compare.
